// File: rtl/harris_corner_nms_pkg.sv
// Shared constants and types for the Harris corner NMS stage.
// Coordinate widths come from coord_w() so a 1-pixel dimension still gets a 1-bit field.
package harris_pkg;

    localparam int DROP_W      = 16;
    localparam int IMAGE_W_DEF = 640;
    localparam int IMAGE_H_DEF = 480;
    localparam int SCORE_W_DEF = 8;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int X_W_DEF = coord_w(IMAGE_W_DEF);
    localparam int Y_W_DEF = coord_w(IMAGE_H_DEF);

    typedef struct packed {
        logic [X_W_DEF-1:0]     x;
        logic [Y_W_DEF-1:0]     y;
        logic [SCORE_W_DEF-1:0] score;
    } det_t;

endpackage

// File: rtl/line_buffer_2r.sv
// Two-line shift buffer feeding rows 0 and 1 of a 3x3 window; one line of storage per row.
// Latency: combinational read at i_addr, write on the same i_en edge.
// Backpressure: none; advances only on i_en.
module line_buffer_2r #(
    parameter int Depth = 640,
    parameter int Width = 8,
    localparam int AW   = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [Width-1:0] i_pix,
    output logic [Width-1:0] o_row0,
    output logic [Width-1:0] o_row1
);

    logic [Width-1:0] r_line0 [Depth];
    logic [Width-1:0] r_line1 [Depth];

    assign o_row1 = r_line1[i_addr];
    assign o_row0 = r_line0[i_addr];

    // Row 1 cascades into row 0 so the pair always holds the two previous lines.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_line1[i_addr] <= i_pix;
            r_line0[i_addr] <= r_line1[i_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock valid/ready FIFO, power-of-2 depth.
// Latency: write visible on o_rd_vld the cycle after the write edge.
// Backpressure: o_wr_rdy low only when full and the head is not popped this cycle.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16,
    localparam int AW   = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_vld,
    output logic             o_wr_rdy,
    input  logic [Width-1:0] i_wr_dat,
    output logic             o_rd_vld,
    input  logic             i_rd_rdy,
    output logic [Width-1:0] o_rd_dat
);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full   = (r_cnt == (AW+1)'(Depth));
    assign o_rd_vld = (r_cnt != '0);
    assign w_pop    = o_rd_vld & i_rd_rdy;
    assign o_wr_rdy = ~w_full | w_pop;
    assign w_push   = i_wr_vld & o_wr_rdy;
    assign o_rd_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

endmodule

// File: rtl/harris_corner_nms.sv
// 3x3 non-maximum suppression on the Harris response stream; emits (x, y, score) of strict local maxima.
// Latency: 3 edges from pixel accept to out_valid; 1 pixel/clock sustained.
// Backpressure: out_ready pops the detection FIFO; detections arriving while it is full are dropped and counted.
module harris_corner_nms
    import harris_pkg::*;
#(
    parameter int ImageW    = 640,
    parameter int ImageH    = 480,
    parameter int outW      = 8,
    parameter int FifoDepth = 16,
    localparam int XW       = coord_w(ImageW),
    localparam int YW       = coord_w(ImageH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sof,
    input  logic [outW-1:0]   response,
    input  logic [outW-1:0]   thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XW-1:0]     corner_x,
    output logic [YW-1:0]     corner_y,
    output logic [outW-1:0]   corner_score,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef struct packed {
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [outW-1:0] score;
    } det_rec_t;

    localparam logic [XW-1:0] XMAX = XW'(ImageW - 1);
    localparam logic [YW-1:0] YMAX = YW'(ImageH - 1);

    logic [XW-1:0]          r_x, w_px, w_nx, r_cx;
    logic [YW-1:0]          r_y, w_py, w_ny, r_cy;
    logic [outW-1:0]        r_thr;
    logic [outW-1:0]        w_row0, w_row1, w_c;
    logic [2:0][2:0][outW-1:0] r_win;
    logic                   r_win_vld;
    logic                   w_start, w_hit;
    logic                   r_det_v;
    det_rec_t               r_det, w_head;
    logic                   w_push, w_wr_rdy, w_drop;
    logic [DROP_W-1:0]      r_drop_cnt;

    assign w_start = en & sof;
    assign w_px    = w_start ? '0 : r_x;
    assign w_py    = w_start ? '0 : r_y;

    always_comb begin
        w_nx = w_px + XW'(1);
        w_ny = w_py;
        if (w_px == XMAX) begin
            w_nx = '0;
            if (w_py != YMAX) w_ny = w_py + YW'(1);
        end
    end

    line_buffer_2r #(.Depth(ImageW), .Width(outW)) u_lb (
        .clk    (clk),
        .i_en   (en),
        .i_addr (w_px),
        .i_pix  (response),
        .o_row0 (w_row0),
        .o_row1 (w_row1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_thr     <= '0;
            r_win     <= '0;
            r_win_vld <= 1'b0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else begin
            r_win_vld <= en && (w_px >= XW'(2)) && (w_py >= YW'(2));
            if (w_start) r_thr <= thresh;
            if (en) begin
                r_x <= w_nx;
                r_y <= w_ny;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_row0;
                r_win[1][2] <= w_row1;
                r_win[2][2] <= response;
                r_cx        <= w_px - XW'(1);
                r_cy        <= w_py - YW'(1);
            end
        end
    end

    // Ties resolve toward the last raster pixel of a plateau: >= earlier neighbours, > later ones.
    assign w_c   = r_win[1][1];
    assign w_hit = (w_c >  r_thr)
                 && (w_c >= r_win[0][0]) && (w_c >= r_win[0][1])
                 && (w_c >= r_win[0][2]) && (w_c >= r_win[1][0])
                 && (w_c >  r_win[1][2]) && (w_c >  r_win[2][0])
                 && (w_c >  r_win[2][1]) && (w_c >  r_win[2][2]);

    // A new frame kills anything still in flight so no old-frame coordinates leak past it.
    assign w_push = r_det_v & ~w_start;
    assign w_drop = w_push & ~w_wr_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_v    <= 1'b0;
            r_det      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_det_v <= r_win_vld & w_hit & ~w_start;
            if (r_win_vld) r_det <= '{x: r_cx, y: r_cy, score: w_c};
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    sync_fifo #(.Width($bits(det_rec_t)), .Depth(FifoDepth)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_push),
        .o_wr_rdy (w_wr_rdy),
        .i_wr_dat (r_det),
        .o_rd_vld (out_valid),
        .i_rd_rdy (out_ready),
        .o_rd_dat (w_head)
    );

    assign corner_x     = out_valid ? w_head.x     : '0;
    assign corner_y     = out_valid ? w_head.y     : '0;
    assign corner_score = out_valid ? w_head.score : '0;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_harris_corner_nms.sv
// Scoreboard bench for harris_corner_nms on an 8x6 frame with a 4-deep detection FIFO.
module tb_harris_corner_nms;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] s;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sof = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  response = '0;
    logic [7:0]  thresh = '0;
    logic        out_valid;
    logic [2:0]  corner_x;
    logic [2:0]  corner_y;
    logic [7:0]  corner_score;
    logic [15:0] drop_cnt;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    logic [7:0] img [N];

    always #5 clk = ~clk;

    harris_corner_nms #(
        .ImageW(W), .ImageH(H), .outW(8), .FifoDepth(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sof          (sof),
        .response     (response),
        .thresh       (thresh),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .corner_x     (corner_x),
        .corner_y     (corner_y),
        .corner_score (corner_score),
        .drop_cnt     (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is popped against the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rec_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_det actual x=%0d y=%0d score=%0d required none",
                         corner_x, corner_y, corner_score);
            end else begin
                e = exp_q.pop_front();
                if ({corner_x, corner_y, corner_score} !== e) begin
                    errors++;
                    $display("FAIL det_mismatch actual x=%0d y=%0d score=%0d required x=%0d y=%0d score=%0d",
                             corner_x, corner_y, corner_score, e.x, e.y, e.s);
                end
            end
        end
    end

    task automatic push_exp(input int x, input int y, input int s);
        rec_t r;
        r.x = x[2:0];
        r.y = y[2:0];
        r.s = s[7:0];
        exp_q.push_back(r);
    endtask

    task automatic clear_img(input logic [7:0] v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic setpix(input int x, input int y, input logic [7:0] v);
        img[y*W + x] = v;
    endtask

    task automatic idle(input int n);
        en  = 1'b0;
        sof = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first npix pixels of img; lat_idx >= 0 checks accept-to-visible latency (gap-free only).
    task automatic send_frame(input int gaps, input int npix, input logic [7:0] thr0,
                              input logic [7:0] thr1, input int lat_idx);
        int cnt;
        cnt = -1;
        for (int i = 0; i < npix; i++) begin
            if (gaps != 0) begin
                int g;
                g = int'($urandom_range(0, 2));
                en  = 1'b0;
                sof = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            en       = 1'b1;
            sof      = (i == 0);
            response = img[i];
            thresh   = (i == 0) ? thr0 : thr1;
            @(posedge clk);
            #1;
            if (cnt >= 0) cnt++;
            if (i == lat_idx) cnt = 0;
            if (cnt == 1) chk("lat_edge1_valid", 32'(out_valid), 0);
            if (cnt == 2) chk("lat_edge2_valid", 32'(out_valid), 1);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        out_ready = 1'b1;
        en        = 1'b0;
        sof       = 1'b0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_drained"}, 32'(exp_q.size()), 0);
        chk({name, "_idle_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_x", 32'(corner_x), 0);
        chk("reset_y", 32'(corner_y), 0);
        chk("reset_score", 32'(corner_score), 0);
        chk("reset_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        idle(2);

        // Single peak, latency measured from acceptance of pixel (4,3).
        clear_img(8'd5);
        setpix(3, 2, 8'd50);
        push_exp(3, 2, 50);
        out_ready = 1'b1;
        send_frame(0, N, 8'd10, 8'd10, 3*W + 4);
        drain("single");

        // Plateau: last raster pixel wins.
        clear_img(8'd0);
        setpix(3, 2, 8'd40);
        setpix(4, 2, 8'd40);
        push_exp(4, 2, 40);
        send_frame(0, N, 8'd10, 8'd10, -1);
        drain("plateau");

        // Border pixels and score equal to threshold never fire; threshold only latched at sof.
        clear_img(8'd0);
        setpix(0, 0, 8'd200);
        setpix(7, 5, 8'd200);
        setpix(2, 2, 8'd10);
        send_frame(0, N, 8'd10, 8'd10, -1);
        drain("thr_equal");
        send_frame(0, N, 8'd10, 8'd9, -1);
        drain("thr_midframe");
        push_exp(2, 2, 10);
        send_frame(0, N, 8'd9, 8'd9, -1);
        drain("thr_next_sof");

        // Overflow: six peaks into a 4-deep FIFO while stalled.
        clear_img(8'd0);
        setpix(1, 1, 8'd100);
        setpix(3, 1, 8'd101);
        setpix(5, 1, 8'd102);
        setpix(1, 3, 8'd103);
        setpix(3, 3, 8'd104);
        setpix(5, 3, 8'd105);
        push_exp(1, 1, 100);
        push_exp(3, 1, 101);
        push_exp(5, 1, 102);
        push_exp(1, 3, 103);
        out_ready = 1'b0;
        send_frame(0, N, 8'd10, 8'd10, -1);
        idle(5);
        chk("ovf_drop_cnt", 32'(drop_cnt), 2);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_x", 32'(corner_x), 1);
            chk("stall_y", 32'(corner_y), 1);
            chk("stall_score", 32'(corner_score), 100);
            idle(3);
        end
        drain("overflow");
        chk("ovf_drop_hold", 32'(drop_cnt), 2);

        // Random en gaps over the single-peak frame.
        clear_img(8'd5);
        setpix(3, 2, 8'd50);
        push_exp(3, 2, 50);
        send_frame(1, N, 8'd10, 8'd10, -1);
        drain("en_gaps");

        // sof lands on the pixel that would have been (5,3); the old peak must not appear.
        clear_img(8'd5);
        setpix(3, 2, 8'd50);
        send_frame(0, 3*W + 5, 8'd10, 8'd10, -1);
        clear_img(8'd5);
        setpix(5, 3, 8'd60);
        push_exp(5, 3, 60);
        send_frame(0, N, 8'd10, 8'd10, -1);
        drain("mid_sof");

        // Asynchronous reset with a held detection, mid-frame.
        out_ready = 1'b0;
        clear_img(8'd5);
        setpix(3, 2, 8'd50);
        send_frame(0, N, 8'd10, 8'd10, -1);
        idle(5);
        chk("pre_reset_valid", 32'(out_valid), 1);
        chk("pre_reset_score", 32'(corner_score), 50);
        send_frame(0, 20, 8'd10, 8'd10, -1);
        en = 1'b0;
        sof = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_x", 32'(corner_x), 0);
        chk("arst_y", 32'(corner_y), 0);
        chk("arst_score", 32'(corner_score), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        push_exp(3, 2, 50);
        out_ready = 1'b1;
        send_frame(0, N, 8'd10, 8'd10, -1);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
